// File: rtl/controlador_varredura.sv
// Column scan controller for the 7x5 LED matrix: column index/enable generation
// plus a double-buffered frame store that only swaps at the frame boundary.
module controlador_varredura #(
  parameter int DIV_COLUNA = 1000,
  parameter int APAGAMENTO = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        habilita,
  input  logic [34:0] quadro_in,
  input  logic        quadro_valido,
  output logic        quadro_pronto,
  output logic [2:0]  contador,
  output logic        enable,
  output logic [6:0]  mapa0,
  output logic [6:0]  mapa1,
  output logic [6:0]  mapa2,
  output logic [6:0]  mapa3,
  output logic [6:0]  mapa4,
  output logic        fim_quadro
);

  localparam int PW = (DIV_COLUNA > 1) ? $clog2(DIV_COLUNA) : 1;
  localparam logic [PW-1:0] P_ULTIMO = PW'(DIV_COLUNA - 1);
  localparam logic [PW-1:0] P_APAG   = PW'(APAGAMENTO);

  typedef enum logic [1:0] {
    DESLIGADO,
    APAGADO,
    ACESO
  } estado_t;

  estado_t       r_estado;
  estado_t       w_proxEstado;
  logic [PW-1:0] r_prescaler;
  logic [PW-1:0] w_proxPrescaler;
  logic [PW-1:0] w_prescalerInc;
  logic [2:0]    r_contador;
  logic [2:0]    w_proxContador;
  logic          r_fim;
  logic          w_proxFim;
  logic          r_pend;
  logic [34:0]   r_sombra;
  logic [34:0]   r_quadro;
  logic          w_tick;
  logic          w_aceita;
  logic          w_troca;

  assign w_prescalerInc = r_prescaler + 1'b1;
  assign w_tick         = (r_prescaler == P_ULTIMO) && habilita;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= DESLIGADO;
      r_prescaler <= '0;
      r_contador  <= 3'd0;
      r_fim       <= 1'b0;
    end else begin
      r_estado    <= w_proxEstado;
      r_prescaler <= w_proxPrescaler;
      r_contador  <= w_proxContador;
      r_fim       <= w_proxFim;
    end
  end

  // Dropping habilita abandons the current column outright, whatever the state.
  always_comb begin
    w_proxEstado    = r_estado;
    w_proxPrescaler = r_prescaler;
    w_proxContador  = r_contador;
    w_proxFim       = 1'b0;
    if (!habilita) begin
      w_proxEstado    = DESLIGADO;
      w_proxPrescaler = '0;
      w_proxContador  = 3'd0;
    end else begin
      case (r_estado)
        DESLIGADO: begin
          w_proxEstado    = APAGADO;
          w_proxPrescaler = '0;
        end
        APAGADO: begin
          w_proxPrescaler = w_prescalerInc;
          if (w_prescalerInc >= P_APAG) begin
            w_proxEstado = ACESO;
          end
        end
        ACESO: begin
          if (w_tick) begin
            w_proxEstado    = APAGADO;
            w_proxPrescaler = '0;
            w_proxContador  = (r_contador == 3'd4) ? 3'd0 : r_contador + 3'd1;
            w_proxFim       = (r_contador == 3'd4);
          end else begin
            w_proxPrescaler = w_prescalerInc;
          end
        end
        default: begin
          w_proxEstado    = DESLIGADO;
          w_proxPrescaler = '0;
          w_proxContador  = 3'd0;
        end
      endcase
    end
  end

  // Accept and swap are mutually exclusive through r_pend, so a frame offered
  // on the swap cycle waits one clock for quadro_pronto.
  assign w_aceita = quadro_valido && !r_pend;
  assign w_troca  = r_pend && ((r_estado == DESLIGADO) ||
                               ((r_estado == ACESO) && w_tick && (r_contador == 3'd4)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= 1'b0;
      r_sombra <= '0;
      r_quadro <= '0;
    end else if (w_aceita) begin
      r_pend   <= 1'b1;
      r_sombra <= quadro_in;
    end else if (w_troca) begin
      r_pend   <= 1'b0;
      r_quadro <= r_sombra;
    end
  end

  assign quadro_pronto = !r_pend;
  assign contador      = r_contador;
  assign enable        = (r_estado == ACESO);
  assign fim_quadro    = r_fim;
  assign mapa0         = r_quadro[34:28];
  assign mapa1         = r_quadro[27:21];
  assign mapa2         = r_quadro[20:14];
  assign mapa3         = r_quadro[13:7];
  assign mapa4         = r_quadro[6:0];

endmodule
